// File: rtl/sum3_pkg.sv
// Shared types and constants for the three-operand sum collector.
// Optional compare outputs are enabled by defining SUM3_CMP_EN.
package sum3_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_C   = 2'd2,
        S_OUT = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 4;

    // Width of a sum of three WIDTH-bit operands, with no truncation.
    function automatic int sum_w(input int width);
        return width + 2;
    endfunction

    localparam int SUM_W = sum_w(WIDTH_DEF);

endpackage

// File: rtl/add3_w.sv
// Combinational adder for three WIDTH-bit operands with a WIDTH+2-bit result.
module add3_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH+1:0] sum
);

    always_comb begin
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
    end

endmodule

// File: rtl/sum3_collector.sv
// Collects three operands and presents their registered sum.
// Defining SUM3_CMP_EN adds the cmp_ref input and the cmp_gt/cmp_lt/cmp_eq flags.
module sum3_collector
    import sum3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_clr,
    output logic [WIDTH+1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SUM3_CMP_EN
    input  logic [WIDTH+1:0] cmp_ref,
    output logic             cmp_gt,
    output logic             cmp_lt,
    output logic             cmp_eq,
`endif
    output logic [1:0]       dbg_state
);

    localparam int SW = sum_w(WIDTH);

    // Handshakes: a beat moves on a rising edge only when valid and ready are both 1;
    // in_clr wins over both sides. in_ready/out_valid decode the state register only.
    state_t          state_q;
    state_t          state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SW-1:0]    sum_new;
    logic             xfer;
    logic             done;

    add3_w #(.WIDTH(WIDTH)) u_add (
        .a   (a_q),
        .b   (b_q),
        .c   (in_data),
        .sum (sum_new)
    );

    assign in_ready  = (state_q != S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign xfer      = in_valid & in_ready & ~in_clr;
    assign done      = out_valid & out_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_clr) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (xfer) state_d = S_B;
                S_B:     if (xfer) state_d = S_C;
                S_C:     if (xfer) state_d = S_OUT;
                S_OUT:   if (done) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    // out_sum is deliberately untouched by in_clr; only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_sum <= '0;
        end else if (in_clr) begin
            a_q <= '0;
            b_q <= '0;
        end else if (xfer) begin
            case (state_q)
                S_A:     a_q     <= in_data;
                S_B:     b_q     <= in_data;
                S_C:     out_sum <= sum_new;
                default: ;
            endcase
        end
    end

`ifdef SUM3_CMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_gt <= 1'b0;
            cmp_lt <= 1'b0;
            cmp_eq <= 1'b0;
        end else if (in_clr || done) begin
            cmp_gt <= 1'b0;
            cmp_lt <= 1'b0;
            cmp_eq <= 1'b0;
        end else if (xfer && state_q == S_C) begin
            cmp_gt <= (sum_new >  cmp_ref);
            cmp_lt <= (sum_new <  cmp_ref);
            cmp_eq <= (sum_new == cmp_ref);
        end
    end
`endif

endmodule

// File: tb/tb_sum3_collector.sv
// Scoreboard bench for sum3_collector: directed cases plus randomized traffic.
// Compare-flag checks are built only when SUM3_CMP_EN is defined.
module tb_sum3_collector;
    import sum3_pkg::*;

    localparam int W  = 4;
    localparam int SW = W + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_clr = 1'b0;
    logic [SW-1:0] out_sum;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    dbg_state;
    logic          rand_mode = 1'b0;
    logic          fix_ready = 1'b1;
    logic          rnd_ready = 1'b1;
`ifdef SUM3_CMP_EN
    logic [SW-1:0] cmp_ref = '0;
    logic          cmp_gt;
    logic          cmp_lt;
    logic          cmp_eq;
    logic [2:0]    exp_cmp_q[$];
`endif

    logic [SW-1:0] exp_q[$];
    int            ops[$];
    int            n_checks = 0;
    int            n_fail = 0;

    assign out_ready = rand_mode ? rnd_ready : fix_ready;

    sum3_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_clr    (in_clr),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SUM3_CMP_EN
        .cmp_ref   (cmp_ref),
        .cmp_gt    (cmp_gt),
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 2) != 0);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: every third accepted operand completes a sum.
    function automatic void model_accept(input int d);
        int s;
        ops.push_back(d);
        if (ops.size() == 3) begin
            s = ops[0] + ops[1] + ops[2];
            exp_q.push_back(SW'(s));
`ifdef SUM3_CMP_EN
            if (s > int'(cmp_ref))      exp_cmp_q.push_back(3'b100);
            else if (s < int'(cmp_ref)) exp_cmp_q.push_back(3'b010);
            else                        exp_cmp_q.push_back(3'b001);
`endif
            ops.delete();
        end
    endfunction

    function automatic void model_flush();
        ops.delete();
        exp_q.delete();
`ifdef SUM3_CMP_EN
        exp_cmp_q.delete();
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the operand is taken.
    task automatic send(input int d);
        int t = 0;
        in_data  = W'(d);
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            model_accept(d);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_clr(input logic with_valid);
        in_clr   = 1'b1;
        in_valid = with_valid;
        in_data  = W'($urandom_range(0, (1 << W) - 1));
        @(posedge clk);
        #1;
        in_clr   = 1'b0;
        in_valid = 1'b0;
        model_flush();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            if (out_valid && exp_q.size() != 0) begin
                check("out_sum", 32'(out_sum), 32'(exp_q[0]));
`ifdef SUM3_CMP_EN
                check("cmp_flags", 32'({cmp_gt, cmp_lt, cmp_eq}), 32'(exp_cmp_q[0]));
`endif
                if (out_ready && !in_clr) begin
                    void'(exp_q.pop_front());
`ifdef SUM3_CMP_EN
                    void'(exp_cmp_q.pop_front());
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] held;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(S_A));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic sum, back-to-back, single-cycle result
        fix_ready = 1'b1;
        send(3); send(5); send(7);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_in_ready", 32'(in_ready), 32'd0);
        check("basic_sum", 32'(out_sum), 32'd15);
        @(posedge clk);
        #1;
        check("basic_one_cycle", 32'(out_valid), 32'd0);

        // Maximum operands
        send(15); send(15); send(15);
        check("max_sum", 32'(out_sum), 32'd45);
        @(posedge clk);
        #1;

        // Backpressure
        fix_ready = 1'b0;
        send(1); send(2); send(3);
        repeat (5) @(negedge clk);
        check("bp_sum", 32'(out_sum), 32'd6);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fix_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_state", 32'(dbg_state), 32'(S_A));

        // Abort partial operands with in_valid high
        send(4); send(9);
        do_clr(1'b1);
        check("abort_state", 32'(dbg_state), 32'(S_A));
        send(1); send(1); send(1);
        check("abort_then_sum", 32'(out_sum), 32'd3);
        @(posedge clk);
        #1;

        // Clear a pending result while out_ready is high: sum is kept, valid drops
        send(6); send(2); send(9);
        held = 6'd17;
        do_clr(1'b0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_out_sum_kept", 32'(out_sum), 32'(held));

        // Asynchronous reset while holding a result
        fix_ready = 1'b0;
        send(5); send(6); send(7);
        #2;
        rst_n = 1'b0;
        model_flush();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_sum", 32'(out_sum), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fix_ready = 1'b1;
        send(2);
        check("arst_first_xfer", 32'(dbg_state), 32'(S_B));
        send(2); send(2);
        check("arst_then_sum", 32'(out_sum), 32'd6);
        @(posedge clk);
        #1;

`ifdef SUM3_CMP_EN
        cmp_ref = 6'd10;
        send(2); send(3); send(5);
        check("cmp_eq", 32'({cmp_gt, cmp_lt, cmp_eq}), 32'b001);
        @(posedge clk); #1;
        send(7); send(7); send(7);
        check("cmp_gt", 32'({cmp_gt, cmp_lt, cmp_eq}), 32'b100);
        do_clr(1'b0);
        check("cmp_clr", 32'({cmp_gt, cmp_lt, cmp_eq}), 32'b000);
        send(0); send(0); send(1);
        check("cmp_lt", 32'({cmp_gt, cmp_lt, cmp_eq}), 32'b010);
        @(posedge clk); #1;
`endif

        // Randomized traffic with random backpressure and occasional clears
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
`ifdef SUM3_CMP_EN
            cmp_ref = SW'($urandom_range(0, 45));
`endif
            if ($urandom_range(0, 24) == 0) do_clr(1'($urandom_range(0, 1)));
            else send(int'($urandom_range(0, (1 << W) - 1)));
        end
        rand_mode = 1'b0;
        fix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
